// File: rtl/fft_frame_feeder_if.sv
// Streaming bundle between an upstream sample source and the FFT input feeder.
// The master modport is the side that produces samples and controls hold.
// The slave modport is the feeder, which drives the fft start_ip/ip burst.
interface fft_frame_feeder_if #(
  parameter int W = 16
);
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic         hold;
  logic         start_ip;
  logic [W-1:0] ip;
  logic         busy;
  logic         frame_err;

  modport master (
    output in_data, in_valid, in_last, hold,
    input  in_ready, start_ip, ip, busy, frame_err
  );

  modport slave (
    input  in_data, in_valid, in_last, hold,
    output in_ready, start_ip, ip, busy, frame_err
  );
endinterface

// File: rtl/fft_frame_feeder.sv
// Ping-pong frame collector feeding the R2SDF fft input port.
// Upstream samples fill one bank while the other bank is replayed as a
// contiguous burst (start_ip on sample 0, one sample per clock). When a frame
// finishes streaming and the other bank is already full, the next burst
// follows on the very next cycle with no gap.
module fft_frame_feeder #(
  parameter int N = 3,
  parameter int W = 16
) (
  input logic              clk,
  input logic              reset,
  fft_frame_feeder_if.slave bus
);

  localparam int DEPTH = 1 << N;
  localparam logic [N-1:0] IDX_ZERO = {N{1'b0}};
  localparam logic [N-1:0] IDX_ONE  = N'(1'b1);
  localparam logic [N-1:0] IDX_LAST = {N{1'b1}};
  localparam logic [W-1:0] DATA_ZERO = {W{1'b0}};

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  // Frame storage and per-bank occupancy
  logic [W-1:0] mem_r [2][DEPTH];
  logic [1:0]   full_r;
  logic [1:0]   full_s;

  // Write side
  logic         wbank_r;
  logic         wbank_s;
  logic [N-1:0] widx_r;
  logic [N-1:0] widx_s;
  logic         in_ready_s;
  logic         wr_accept_s;
  logic         wr_complete_s;
  logic         frame_err_s;

  // Read side
  state_t       state_r;
  state_t       state_s;
  logic         rbank_r;
  logic         rbank_s;
  logic [N-1:0] ridx_r;
  logic [N-1:0] ridx_s;
  logic         rd_go_s;
  logic         rd_release_s;

  // Registered outputs
  logic         start_ip_r;
  logic         start_ip_s;
  logic [W-1:0] ip_r;
  logic [W-1:0] ip_s;
  logic         busy_r;
  logic         busy_s;
  logic         frame_err_r;

  // The write bank accepts data whenever it does not still hold an unsent frame
  assign in_ready_s  = ~full_r[wbank_r];
  assign wr_accept_s = bus.in_valid & in_ready_s;
  assign rd_go_s     = full_r[rbank_r] & ~bus.hold;

  assign bus.in_ready  = in_ready_s;
  assign bus.start_ip  = start_ip_r;
  assign bus.ip        = ip_r;
  assign bus.busy      = busy_r;
  assign bus.frame_err = frame_err_r;

  // Write-side framing: complete a frame, or discard it on a misplaced/missing last
  always_comb begin
    widx_s        = widx_r;
    wbank_s       = wbank_r;
    wr_complete_s = 1'b0;
    frame_err_s   = 1'b0;
    if (wr_accept_s) begin
      if (bus.in_last && (widx_r == IDX_LAST)) begin
        wr_complete_s = 1'b1;
        wbank_s       = ~wbank_r;
        widx_s        = IDX_ZERO;
      end else if (bus.in_last || (widx_r == IDX_LAST)) begin
        frame_err_s = 1'b1;
        widx_s      = IDX_ZERO;
      end else begin
        widx_s = widx_r + IDX_ONE;
      end
    end else begin
      widx_s = widx_r;
    end
  end

  // Bank occupancy: writer marks a bank full, reader frees it after its last sample
  always_comb begin
    full_s    = full_r;
    full_s[0] = (full_r[0] | (wr_complete_s & ~wbank_r)) & ~(rd_release_s & ~rbank_r);
    full_s[1] = (full_r[1] | (wr_complete_s &  wbank_r)) & ~(rd_release_s &  rbank_r);
  end

  // Read FSM next-state and burst outputs; ridx wrapping to zero marks a frame boundary
  always_comb begin
    state_s      = state_r;
    rbank_s      = rbank_r;
    ridx_s       = ridx_r;
    start_ip_s   = 1'b0;
    ip_s         = DATA_ZERO;
    busy_s       = 1'b0;
    rd_release_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rd_go_s) begin
          start_ip_s = 1'b1;
          ip_s       = mem_r[rbank_r][IDX_ZERO];
          busy_s     = 1'b1;
          ridx_s     = IDX_ONE;
          state_s    = ST_STREAM;
        end else begin
          ridx_s  = IDX_ZERO;
          state_s = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (ridx_r == IDX_ZERO) begin
          // Previous frame fully emitted; chain the next one if it is ready
          if (rd_go_s) begin
            start_ip_s = 1'b1;
            ip_s       = mem_r[rbank_r][IDX_ZERO];
            busy_s     = 1'b1;
            ridx_s     = IDX_ONE;
            state_s    = ST_STREAM;
          end else begin
            ridx_s  = IDX_ZERO;
            state_s = ST_IDLE;
          end
        end else begin
          ip_s   = mem_r[rbank_r][ridx_r];
          busy_s = 1'b1;
          ridx_s = ridx_r + IDX_ONE;
          if (ridx_r == IDX_LAST) begin
            rd_release_s = 1'b1;
            rbank_s      = ~rbank_r;
          end else begin
            rd_release_s = 1'b0;
          end
        end
      end
      default: begin
        state_s = ST_IDLE;
        ridx_s  = IDX_ZERO;
      end
    endcase
  end

  // Control state and registered outputs; reset drops every buffered frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_r      <= 2'b00;
      wbank_r     <= 1'b0;
      widx_r      <= IDX_ZERO;
      state_r     <= ST_IDLE;
      rbank_r     <= 1'b0;
      ridx_r      <= IDX_ZERO;
      start_ip_r  <= 1'b0;
      ip_r        <= DATA_ZERO;
      busy_r      <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      full_r      <= full_s;
      wbank_r     <= wbank_s;
      widx_r      <= widx_s;
      state_r     <= state_s;
      rbank_r     <= rbank_s;
      ridx_r      <= ridx_s;
      start_ip_r  <= start_ip_s;
      ip_r        <= ip_s;
      busy_r      <= busy_s;
      frame_err_r <= frame_err_s;
    end
  end

  // Sample storage; contents are only ever read behind a full flag, so no reset is needed
  always_ff @(posedge clk) begin
    if (wr_accept_s) begin
      mem_r[wbank_r][widx_r] <= bus.in_data;
    end
  end

endmodule
